mem_bist_ctrl: RTL and testbench

- Initiator for the 1K x 8 single-port memory interface (en, wr_rd, addr, wr_data, rd_data).
- On start, runs a two-pass write/read-back self-test over every address:
  - W0: write pattern P to all addresses.
  - R0: read back all addresses and compare with P.
  - W1: write ~P to all addresses.
  - R1: read back all addresses and compare with ~P.
- Reports pass/fail, error count, and the first failing address and pass.
- Sits between system control and the memory; the memory requires no changes.

---
 rtl/mem_bist_if.sv | 27 ++
 rtl/mem_bist_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_if.sv
// Command/response bus between the BIST controller and a 1K x 8 single-port memory.
interface mem_bist_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              mem_en;
    logic              mem_wr_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_en,
        output mem_wr_rd,
        output mem_addr,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_en,
        input  mem_wr_rd,
        input  mem_addr,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read-back memory self-test controller.
// Pass 0 writes P(a) = a ^ SEED then reads it back; pass 1 does the same with ~P(a).
// Read data is compared RD_LAT cycles after each read command via a tag pipeline.
module mem_bist_ctrl #(
    parameter int              ADDR_W = 10,
    parameter int              DATA_W = 8,
    parameter int              DEPTH  = 1024,
    parameter int              RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED = 'hA5,
    parameter int              CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mem_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_pass,
    output logic              fail_valid
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0,
        S_DRAIN0,
        S_W1,
        S_R1,
        S_DRAIN1,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT_W-1:0]  lat_q;
    logic              last_addr;
    logic              last_lat;
    logic              start_ok;
    logic              in_drain;

    logic              cmd_en;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rd_issue;
    logic              rd_pass;
    logic [DATA_W-1:0] exp_data;
    logic              busy_c;

    // Tag pipeline: one entry per outstanding read, output stage is RD_LAT-1
    logic              vld_p  [RD_LAT];
    logic [DATA_W-1:0] exp_p  [RD_LAT];
    logic [ADDR_W-1:0] addr_p [RD_LAT];
    logic              pass_p [RD_LAT];
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
    assign last_lat  = (lat_q == LAT_W'(RD_LAT - 1));
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign in_drain  = (state == S_DRAIN0) || (state == S_DRAIN1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and memory command decode
    always_comb begin
        state_nxt = state;
        cmd_en    = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rd_issue  = 1'b0;
        rd_pass   = 1'b0;
        exp_data  = '0;
        busy_c    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_W0;
            end
            S_W0: begin
                busy_c   = 1'b1;
                cmd_en   = 1'b1;
                cmd_wr   = 1'b1;
                cmd_addr = addr_q;
                cmd_data = pattern(addr_q);
                if (last_addr) state_nxt = S_R0;
            end
            S_R0: begin
                busy_c   = 1'b1;
                cmd_en   = 1'b1;
                cmd_addr = addr_q;
                rd_issue = 1'b1;
                exp_data = pattern(addr_q);
                if (last_addr) state_nxt = S_DRAIN0;
            end
            S_DRAIN0: begin
                busy_c = 1'b1;
                if (last_lat) state_nxt = S_W1;
            end
            S_W1: begin
                busy_c   = 1'b1;
                cmd_en   = 1'b1;
                cmd_wr   = 1'b1;
                cmd_addr = addr_q;
                cmd_data = ~pattern(addr_q);
                if (last_addr) state_nxt = S_R1;
            end
            S_R1: begin
                busy_c   = 1'b1;
                cmd_en   = 1'b1;
                cmd_addr = addr_q;
                rd_issue = 1'b1;
                rd_pass  = 1'b1;
                exp_data = ~pattern(addr_q);
                if (last_addr) state_nxt = S_DRAIN1;
            end
            S_DRAIN1: begin
                busy_c = 1'b1;
                if (last_lat) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem.mem_en      = cmd_en;
    assign mem.mem_wr_rd   = cmd_wr;
    assign mem.mem_addr    = cmd_addr;
    assign mem.mem_wr_data = cmd_data;
    assign busy            = busy_c;
    assign done            = (state == S_DONE);
    // err_cnt saturates rather than wraps, so zero here really means no mismatches
    assign pass            = (state == S_DONE) && (err_cnt == '0);

    // Address counter walks 0..DEPTH-1 per phase; drain counter times the read drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            lat_q  <= '0;
        end else if (start_ok) begin
            addr_q <= '0;
            lat_q  <= '0;
        end else begin
            if (cmd_en)   addr_q <= last_addr ? '0 : addr_q + 1'b1;
            if (in_drain) lat_q  <= last_lat ? '0 : lat_q + 1'b1;
        end
    end

    // Read tag pipeline, stage 0 loaded with the read issued this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                exp_p[i]  <= '0;
                addr_p[i] <= '0;
                pass_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0]  <= rd_issue;
            exp_p[0]  <= exp_data;
            addr_p[0] <= addr_q;
            pass_p[0] <= rd_pass;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                exp_p[i]  <= exp_p[i-1];
                addr_p[i] <= addr_p[i-1];
                pass_p[i] <= pass_p[i-1];
            end
        end
    end

    assign mismatch = vld_p[RD_LAT-1] && (mem.mem_rd_data != exp_p[RD_LAT-1]);

    // Error accounting: saturating count plus first-failure capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_pass  <= 1'b0;
            fail_valid <= 1'b0;
        end else if (start_ok) begin
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_pass  <= 1'b0;
            fail_valid <= 1'b0;
        end else if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (!fail_valid) begin
                fail_addr  <= addr_p[RD_LAT-1];
                fail_pass  <= pass_p[RD_LAT-1];
                fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: instance A (RD_LAT=1, CNT_W=16) and B (RD_LAT=3, CNT_W=8),
// each with a behavioural memory that can inject a stuck bit or tie read data low.
module tb_mem_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    mem_bist_if #(.ADDR_W(10), .DATA_W(8)) bus_a ();
    mem_bist_if #(.ADDR_W(10), .DATA_W(8)) bus_b ();

    logic        busy_a, done_a, pass_a, fp_a, fv_a;
    logic [15:0] err_a;
    logic [9:0]  fa_a;
    logic        busy_b, done_b, pass_b, fp_b, fv_b;
    logic [7:0]  err_b;
    logic [9:0]  fa_b;

    mem_bist_ctrl #(.RD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem(bus_a.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_addr(fa_a), .fail_pass(fp_a), .fail_valid(fv_a)
    );

    mem_bist_ctrl #(.RD_LAT(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem(bus_b.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_addr(fa_b), .fail_pass(fp_b), .fail_valid(fv_b)
    );

    // Memory models: mode 0 ideal, 1 bit0 stuck low at addr 5, 2 read data tied 0
    int         mode_a = 0;
    int         mode_b = 0;
    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];
    logic [7:0] rd_a;
    logic [7:0] rd_b1, rd_b2, rd_b3;

    always @(posedge clk) begin
        if (bus_a.mem_en && bus_a.mem_wr_rd) mem_a[bus_a.mem_addr] <= bus_a.mem_wr_data;
        if (bus_a.mem_en && !bus_a.mem_wr_rd) begin
            if (mode_a == 1 && bus_a.mem_addr == 10'd5) rd_a <= mem_a[5] & 8'hFE;
            else                                        rd_a <= mem_a[bus_a.mem_addr];
        end
    end
    assign bus_a.mem_rd_data = (mode_a == 2) ? 8'h00 : rd_a;

    always @(posedge clk) begin
        if (bus_b.mem_en && bus_b.mem_wr_rd) mem_b[bus_b.mem_addr] <= bus_b.mem_wr_data;
        rd_b1 <= mem_b[bus_b.mem_addr];
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
    end
    assign bus_b.mem_rd_data = (mode_b == 2) ? 8'h00 : rd_b3;

    // Selected-DUT view used by the generic run task
    logic        sel = 1'b0;
    logic        c_busy, c_done, c_pass, c_fv, c_fp, c_en, c_wr;
    logic [15:0] c_err;
    logic [9:0]  c_fa, c_addr;
    logic [7:0]  c_data;
    assign c_busy = sel ? busy_b : busy_a;
    assign c_done = sel ? done_b : done_a;
    assign c_pass = sel ? pass_b : pass_a;
    assign c_fv   = sel ? fv_b : fv_a;
    assign c_fp   = sel ? fp_b : fp_a;
    assign c_err  = sel ? {8'd0, err_b} : err_a;
    assign c_fa   = sel ? fa_b : fa_a;
    assign c_en   = sel ? bus_b.mem_en : bus_a.mem_en;
    assign c_wr   = sel ? bus_b.mem_wr_rd : bus_a.mem_wr_rd;
    assign c_addr = sel ? bus_b.mem_addr : bus_a.mem_addr;
    assign c_data = sel ? bus_b.mem_wr_data : bus_a.mem_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    logic       log_en [3];
    logic       log_wr [3];
    logic [9:0] log_ad [3];
    logic [7:0] log_dt [3];

    // Pulse start on the selected DUT and count busy cycles until it finishes
    task automatic run_test(input bit s, output int bcyc, output int encnt);
        bit fin;
        sel   = s;
        bcyc  = 0;
        encnt = 0;
        fin   = 1'b0;
        @(negedge clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (k < 3) begin
                log_en[k] = c_en;
                log_wr[k] = c_wr;
                log_ad[k] = c_addr;
                log_dt[k] = c_data;
            end
            if (c_en) encnt++;
            if (c_busy) bcyc++;
            else if (bcyc > 0) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk("run_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        string name;
        bit    s;
        int    mode;
        int    busy;
        bit    pass;
        int    err;
        bit    fv;
        int    fa;
        bit    fp;
    } vec_t;

    vec_t vecs [5];
    logic [7:0] first_dat [3];

    initial begin
        int bc, ec, k;
        bit found;

        vecs[0] = '{"a_ideal",    1'b0, 0, 4098, 1'b1, 0,    1'b0, 0, 1'b0};
        vecs[1] = '{"a_stuck5",   1'b0, 1, 4098, 1'b0, 1,    1'b1, 5, 1'b1};
        vecs[2] = '{"a_tie0",     1'b0, 2, 4098, 1'b0, 2040, 1'b1, 0, 1'b0};
        vecs[3] = '{"b_tie0_sat", 1'b1, 2, 4102, 1'b0, 255,  1'b1, 0, 1'b0};
        vecs[4] = '{"b_ideal",    1'b1, 0, 4102, 1'b1, 0,    1'b0, 0, 1'b0};
        first_dat[0] = 8'hA5;
        first_dat[1] = 8'hA4;
        first_dat[2] = 8'hA7;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_en",    bus_a.mem_en, 0);
        chk("rst_wr_rd",     bus_a.mem_wr_rd, 0);
        chk("rst_addr",      bus_a.mem_addr, 0);
        chk("rst_wr_data",   bus_a.mem_wr_data, 0);
        chk("rst_busy",      busy_a, 0);
        chk("rst_done",      done_a, 0);
        chk("rst_pass",      pass_a, 0);
        chk("rst_err",       err_a, 0);
        chk("rst_fail_addr", fa_a, 0);
        chk("rst_fail_pass", fp_a, 0);
        chk("rst_fail_vld",  fv_a, 0);
        chk("rst_b_busy",    busy_b, 0);
        chk("rst_b_en",      bus_b.mem_en, 0);
        rst = 1'b0;

        // Table-driven full runs
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].s) mode_b = vecs[i].mode; else mode_a = vecs[i].mode;
            run_test(vecs[i].s, bc, ec);
            chk({vecs[i].name, "_busy_cycles"}, bc, vecs[i].busy);
            chk({vecs[i].name, "_en_cycles"},   ec, 4096);
            chk({vecs[i].name, "_done"},        c_done, 1);
            chk({vecs[i].name, "_pass"},        c_pass, vecs[i].pass);
            chk({vecs[i].name, "_err_cnt"},     c_err, vecs[i].err);
            chk({vecs[i].name, "_fail_valid"},  c_fv, vecs[i].fv);
            chk({vecs[i].name, "_fail_addr"},   c_fa, vecs[i].fa);
            chk({vecs[i].name, "_fail_pass"},   c_fp, vecs[i].fp);
            for (int j = 0; j < 3; j++) begin
                chk({vecs[i].name, "_cmd_en"},   log_en[j], 1);
                chk({vecs[i].name, "_cmd_wr"},   log_wr[j], 1);
                chk({vecs[i].name, "_cmd_addr"}, log_ad[j], j);
                chk({vecs[i].name, "_cmd_data"}, log_dt[j], first_dat[j]);
            end
        end

        // Reset mid-R0 at address 300 with read data tied low
        mode_a = 2;
        sel    = 1'b0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        found = 1'b0;
        for (k = 0; k < 3000; k++) begin
            if (bus_a.mem_en && !bus_a.mem_wr_rd && bus_a.mem_addr == 10'd300) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reached_r0_300", found, 1);
        chk("midrst_err_before", err_a, 298);
        #1 rst = 1'b1;
        #1;
        chk("midrst_mem_en", bus_a.mem_en, 0);
        chk("midrst_busy",   busy_a, 0);
        chk("midrst_err",    err_a, 0);
        @(negedge clk) rst = 1'b0;
        mode_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk("midrst_restart_en",   bus_a.mem_en, 1);
        chk("midrst_restart_wr",   bus_a.mem_wr_rd, 1);
        chk("midrst_restart_addr", bus_a.mem_addr, 0);
        chk("midrst_restart_data", bus_a.mem_wr_data, 8'hA5);
        for (k = 0; k < 6000 && busy_a; k++) @(negedge clk);
        chk("midrst_final_done", done_a, 1);
        chk("midrst_final_pass", pass_a, 1);

        // start pulsed during W1 is ignored
        bc = 0;
        @(negedge clk) start_a = 1'b1;
        for (k = 0; k < 12000; k++) begin
            @(negedge clk);
            start_a = (k == 2100);
            if (busy_a) bc++;
            else if (bc > 0) break;
        end
        chk("w1start_busy_cycles", bc, 4098);
        chk("w1start_done", done_a, 1);
        chk("w1start_pass", pass_a, 1);
        chk("w1start_err",  err_a, 0);

        // start in DONE restarts and clears the previous result
        mode_a = 2;
        run_test(1'b0, bc, ec);
        chk("restart_prev_err", err_a, 2040);
        mode_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk("restart_done_clr", done_a, 0);
        chk("restart_err_clr",  err_a, 0);
        chk("restart_fv_clr",   fv_a, 0);
        chk("restart_busy",     busy_a, 1);
        for (k = 0; k < 6000 && busy_a; k++) @(negedge clk);
        chk("restart_final_pass", pass_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
